cas_streamer: RTL

CAS_STREAMER -- requirements
Module: cas_streamer

---
 rtl/cas_pkg.sv | 20 ++
 rtl/cas_fetch.sv | 66 ++++++
 rtl/cas_streamer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cas_pkg.sv
// Shared types and constants for the cassette tape streamer.
package cas_pkg;

    // Play-side state machine encoding.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HIGH,
        ST_LOW,
        ST_EOT
    } play_state_t;

    // Default half-period lengths in q_tick pulses (1200 Hz / 2400 Hz tones).
    localparam int HALF0_DEF = 373;
    localparam int HALF1_DEF = 186;

    // Width of the half-period counter.
    localparam int CNT_W = 16;

endpackage

// File: rtl/cas_fetch.sv
// Byte fetch engine: one-deep prefetch buffer, fixed-latency read pipe and
// the tape position counter. At most one read is ever in flight.
module cas_fetch #(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rewind,
    input  logic              take,
    input  logic [ADDR_W-1:0] tape_len,
    input  logic [7:0]        mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] pos,
    output logic              buf_valid,
    output logic [7:0]        buf_data,
    output logic              pending
);

    // lat_pipe[k] is high k+1 cycles after the read strobe.
    logic [MEM_LAT-1:0] lat_pipe;
    logic [MEM_LAT:0]   lat_next;
    logic               capture;
    logic               issue;

    assign lat_next = {lat_pipe, mem_rd};
    assign capture  = lat_pipe[MEM_LAT-1];
    assign pending  = mem_rd | (|lat_pipe);
    assign issue    = !buf_valid && !pending && !rewind && (pos < tape_len);

    // Issue reads, track the in-flight read and capture its data; rewind drops
    // any read in flight so a late return can never land in the buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            lat_pipe  <= '0;
            pos       <= '0;
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else if (rewind) begin
            mem_rd    <= 1'b0;
            lat_pipe  <= '0;
            pos       <= '0;
            buf_valid <= 1'b0;
        end else begin
            mem_rd   <= issue;
            lat_pipe <= lat_next[MEM_LAT-1:0];
            if (issue) begin
                mem_addr <= pos;
            end
            if (capture) begin
                buf_data  <= mem_data;
                buf_valid <= 1'b1;
                // tape_len may have shrunk while the read was in flight
                if (pos < tape_len) begin
                    pos <= pos + 1'b1;
                end
            end else if (take) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cas_streamer.sv
// Cassette tape streamer: fetches tape bytes from memory and plays them out
// LSB first as an FSK bit stream (one cycle of 1200 Hz for a 0, 2400 Hz for a 1).
module cas_streamer
    import cas_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1,
    parameter int HALF0   = HALF0_DEF,
    parameter int HALF1   = HALF1_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              q_tick,
    input  logic              motor,
    input  logic              rewind,
    input  logic [ADDR_W-1:0] tape_len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    output logic              data_out,
    output logic              eot,
    output logic              underrun,
    output logic [ADDR_W-1:0] pos
);

    localparam logic [CNT_W-1:0] LAST0 = CNT_W'(HALF0 - 1);
    localparam logic [CNT_W-1:0] LAST1 = CNT_W'(HALF1 - 1);

    logic [1:0]       rst_sync;
    logic             rst_int_n;
    play_state_t      state;
    logic [7:0]       shift;
    logic [2:0]       bit_idx;
    logic [CNT_W-1:0] cnt;
    logic             drive_hi;
    logic             buf_valid;
    logic [7:0]       buf_data;
    logic             pending;
    logic             adv;
    logic             take;
    logic             half_done;
    logic             end_of_data;

    // Reset asserts immediately but releases only after two clk edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    cas_fetch #(
        .ADDR_W  (ADDR_W),
        .MEM_LAT (MEM_LAT)
    ) u_fetch (
        .clk       (clk),
        .reset_n   (rst_int_n),
        .rewind    (rewind),
        .take      (take),
        .tape_len  (tape_len),
        .mem_data  (mem_data),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .pos       (pos),
        .buf_valid (buf_valid),
        .buf_data  (buf_data),
        .pending   (pending)
    );

    assign adv         = q_tick && motor;
    assign take        = adv && !rewind && (state == ST_LOAD) && buf_valid;
    assign half_done   = (cnt == (shift[0] ? LAST1 : LAST0));
    assign end_of_data = (pos >= tape_len) && !pending && !buf_valid;
    // Dropping the motor silences the output at once, not at the next edge.
    assign data_out    = drive_hi && motor;

    // Play state machine; every step is gated by q_tick with the motor running.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state    <= ST_IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            cnt      <= '0;
            drive_hi <= 1'b0;
            eot      <= 1'b0;
            underrun <= 1'b0;
        end else if (rewind) begin
            state    <= ST_IDLE;
            bit_idx  <= '0;
            cnt      <= '0;
            drive_hi <= 1'b0;
            eot      <= 1'b0;
            underrun <= 1'b0;
        end else if (adv) begin
            case (state)
                ST_IDLE: begin
                    if (end_of_data) begin
                        state <= ST_EOT;
                        eot   <= 1'b1;
                    end else begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Wait here for the very first byte after start/rewind
                    if (buf_valid) begin
                        shift    <= buf_data;
                        bit_idx  <= '0;
                        cnt      <= '0;
                        drive_hi <= 1'b1;
                        state    <= ST_HIGH;
                    end else if (end_of_data) begin
                        state <= ST_EOT;
                        eot   <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (half_done) begin
                        cnt      <= '0;
                        drive_hi <= 1'b0;
                        state    <= ST_LOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (!half_done) begin
                        cnt <= cnt + 1'b1;
                    end else if (bit_idx != 3'd7) begin
                        shift    <= shift >> 1;
                        bit_idx  <= bit_idx + 3'd1;
                        cnt      <= '0;
                        drive_hi <= 1'b1;
                        state    <= ST_HIGH;
                    end else if (buf_valid) begin
                        state <= ST_LOAD;
                    end else if (end_of_data) begin
                        state <= ST_EOT;
                        eot   <= 1'b1;
                    end else begin
                        // Next byte still in flight: hold low, cnt stays on last
                        underrun <= 1'b1;
                    end
                end
                ST_EOT: begin
                    state <= ST_EOT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
